// File: rtl/gray_seq_decoder.sv
// gray_seq_decoder
// Receive-side Gray-code tracker. Decodes each accepted Gray sample to binary.
// Checks that consecutive samples differ by 0 or +/-1 modulo 2^WIDTH.
// Reports step direction, wrap-around events and a signed-modulo wrap count.
// An illegal jump sends the FSM to ERROR.
// Optional build macro GRAY_DEC_STICKY_ERR_EN: when defined, ERROR is terminal
// until Reset; otherwise the next valid sample resynchronises the tracker.

module gray_seq_decoder #(
    parameter int WIDTH      = 3,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  In_valid,
    input  logic [WIDTH-1:0]      Gray_in,
    output logic [WIDTH-1:0]      Bin_out,
    output logic                  Out_valid,
    output logic                  Dir,
    output logic                  Hold,
    output logic                  Step_err,
    output logic                  Wrap,
    output logic [WRAP_CNT_W-1:0] Wrap_count,
    output logic                  Locked,
    output logic                  Err_flag
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_TRACK  = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]      BIN_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0]      BIN_MAX = '1;
    localparam logic [WIDTH-1:0]      BIN_MIN = '0;
    localparam logic [WRAP_CNT_W-1:0] WC_ONE  = WRAP_CNT_W'(1);

    state_t state, state_next;

    logic [WIDTH-1:0]      new_bin;
    logic                  is_same;
    logic                  is_up;
    logic                  is_down;
    logic                  step_legal;

    logic [WIDTH-1:0]      bin_next;
    logic                  out_valid_next;
    logic                  dir_next;
    logic                  hold_next;
    logic                  step_err_next;
    logic                  wrap_next;
    logic [WRAP_CNT_W-1:0] wrap_count_next;
    logic                  err_flag_next;

    // Reflected-binary to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Step classification against the stored reference (Bin_out doubles as the reference).
    always_comb begin
        new_bin    = gray_to_bin(Gray_in);
        is_same    = (new_bin == Bin_out);
        is_up      = (new_bin == Bin_out + BIN_ONE);
        is_down    = (new_bin == Bin_out - BIN_ONE);
        step_legal = is_same | is_up | is_down;
    end

    // State register; Reset takes priority over any valid sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_UNSYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: only accepted samples move the FSM.
    always_comb begin
        state_next = state;
        if (In_valid) begin
            case (state)
                ST_UNSYNC: state_next = ST_TRACK;
                ST_TRACK:  state_next = step_legal ? ST_TRACK : ST_ERROR;
                ST_ERROR: begin
`ifdef GRAY_DEC_STICKY_ERR_EN
                    state_next = ST_ERROR;
`else
                    state_next = ST_TRACK;
`endif
                end
                default:   state_next = ST_UNSYNC;
            endcase
        end
    end

    // Output next-values: pulses default low, levels default to hold.
    always_comb begin
        bin_next        = Bin_out;
        out_valid_next  = 1'b0;
        dir_next        = Dir;
        hold_next       = 1'b0;
        step_err_next   = 1'b0;
        wrap_next       = 1'b0;
        wrap_count_next = Wrap_count;
        err_flag_next   = Err_flag;
        if (In_valid) begin
            case (state)
                ST_UNSYNC: begin
                    bin_next       = new_bin;
                    out_valid_next = 1'b1;
                end
                ST_TRACK: begin
                    bin_next       = new_bin;
                    out_valid_next = 1'b1;
                    if (is_same) begin
                        hold_next = 1'b1;
                    end else if (is_up) begin
                        dir_next = 1'b1;
                        if (Bin_out == BIN_MAX) begin
                            wrap_next       = 1'b1;
                            wrap_count_next = Wrap_count + WC_ONE;
                        end
                    end else if (is_down) begin
                        dir_next = 1'b0;
                        if (Bin_out == BIN_MIN) begin
                            wrap_next       = 1'b1;
                            wrap_count_next = Wrap_count - WC_ONE;
                        end
                    end else begin
                        step_err_next = 1'b1;
                        err_flag_next = 1'b1;
                    end
                end
                ST_ERROR: begin
`ifndef GRAY_DEC_STICKY_ERR_EN
                    bin_next       = new_bin;
                    out_valid_next = 1'b1;
                    err_flag_next  = 1'b0;
`endif
                end
                default: begin
                    bin_next = Bin_out;
                end
            endcase
        end
    end

    // Output registers; everything clears on Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Bin_out    <= '0;
            Out_valid  <= 1'b0;
            Dir        <= 1'b0;
            Hold       <= 1'b0;
            Step_err   <= 1'b0;
            Wrap       <= 1'b0;
            Wrap_count <= '0;
            Err_flag   <= 1'b0;
        end else begin
            Bin_out    <= bin_next;
            Out_valid  <= out_valid_next;
            Dir        <= dir_next;
            Hold       <= hold_next;
            Step_err   <= step_err_next;
            Wrap       <= wrap_next;
            Wrap_count <= wrap_count_next;
            Err_flag   <= err_flag_next;
        end
    end

    assign Locked = (state == ST_TRACK);

endmodule

// File: tb/tb_gray_seq_decoder.sv
// tb_gray_seq_decoder
// Self-checking bench for gray_seq_decoder (WIDTH=3, WRAP_CNT_W=8).
// Directed scenarios followed by randomized stimulus, checked against a table-based reference model.
// Honours GRAY_DEC_STICKY_ERR_EN the same way as the design.

module tb_gray_seq_decoder;

    localparam int W  = 3;
    localparam int N  = 8;
    localparam int CW = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          In_valid;
    logic [W-1:0]  Gray_in;
    logic [W-1:0]  Bin_out;
    logic          Out_valid;
    logic          Dir;
    logic          Hold;
    logic          Step_err;
    logic          Wrap;
    logic [CW-1:0] Wrap_count;
    logic          Locked;
    logic          Err_flag;

    int tests;
    int failures;

    int gray_of [N];
    int bin_of_gray [N];

    // Reference model state: 0 = no reference, 1 = tracking, 2 = error
    int m_state;
    int m_bin;
    int m_ov;
    int m_dir;
    int m_hold;
    int m_serr;
    int m_wrap;
    int m_wc;
    int m_err;

    gray_seq_decoder #(.WIDTH(W), .WRAP_CNT_W(CW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .In_valid   (In_valid),
        .Gray_in    (Gray_in),
        .Bin_out    (Bin_out),
        .Out_valid  (Out_valid),
        .Dir        (Dir),
        .Hold       (Hold),
        .Step_err   (Step_err),
        .Wrap       (Wrap),
        .Wrap_count (Wrap_count),
        .Locked     (Locked),
        .Err_flag   (Err_flag)
    );

    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: one clock edge worth of behaviour, expressed in modular arithmetic.
    task automatic modelStep(input bit rst, input bit vld, input int gray);
        int nb;
        int d;
        if (rst) begin
            m_state = 0; m_bin = 0; m_ov = 0; m_dir = 0; m_hold = 0;
            m_serr = 0; m_wrap = 0; m_wc = 0; m_err = 0;
            return;
        end
        m_ov = 0; m_hold = 0; m_serr = 0; m_wrap = 0;
        if (!vld) return;
        nb = bin_of_gray[gray];
        if (m_state == 0) begin
            m_bin = nb; m_ov = 1; m_state = 1;
        end else if (m_state == 1) begin
            d = (nb - m_bin + N) % N;
            m_ov = 1;
            if (d == 0) begin
                m_hold = 1;
            end else if (d == 1) begin
                m_dir = 1;
                if (m_bin == N - 1) begin m_wrap = 1; m_wc = (m_wc + 1) % 256; end
            end else if (d == N - 1) begin
                m_dir = 0;
                if (m_bin == 0) begin m_wrap = 1; m_wc = (m_wc + 255) % 256; end
            end else begin
                m_serr = 1; m_err = 1; m_state = 2;
            end
            m_bin = nb;
        end else begin
`ifndef GRAY_DEC_STICKY_ERR_EN
            m_bin = nb; m_ov = 1; m_err = 0; m_state = 1;
`endif
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".bin"},    int'(Bin_out),    m_bin);
        checkOutput({tag, ".ov"},     int'(Out_valid),  m_ov);
        checkOutput({tag, ".dir"},    int'(Dir),        m_dir);
        checkOutput({tag, ".hold"},   int'(Hold),       m_hold);
        checkOutput({tag, ".serr"},   int'(Step_err),   m_serr);
        checkOutput({tag, ".wrap"},   int'(Wrap),       m_wrap);
        checkOutput({tag, ".wc"},     int'(Wrap_count), m_wc);
        checkOutput({tag, ".locked"}, int'(Locked),     (m_state == 1) ? 1 : 0);
        checkOutput({tag, ".err"},    int'(Err_flag),   m_err);
    endtask

    // Drive one cycle of inputs away from the active edge, then check just after it.
    task automatic applyStimulus(input string tag, input bit rst, input bit vld, input int gray);
        @(negedge Clk);
        Reset    = rst;
        In_valid = vld;
        Gray_in  = W'(gray);
        @(posedge Clk);
        modelStep(rst, vld, gray);
        #1;
        checkAll(tag);
    endtask

    task automatic doReset(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 0);
    endtask

    initial begin
        int seq1 [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        tests    = 0;
        failures = 0;
        Reset    = 1'b1;
        In_valid = 1'b0;
        Gray_in  = '0;
        for (int i = 0; i < N; i++) begin
            gray_of[i] = i ^ (i >> 1);
            bin_of_gray[i ^ (i >> 1)] = i;
        end
        modelStep(1'b1, 1'b0, 0);

        // Reset state, including Reset winning over a valid sample
        applyStimulus("rst0", 1'b1, 1'b1, 3);
        checkOutput("rst0.zero_bin", int'(Bin_out), 0);
        checkOutput("rst0.zero_wc", int'(Wrap_count), 0);

        // Scenario 1: full up-count through the wrap
        for (int i = 0; i < 9; i++) applyStimulus("s1", 1'b0, 1'b1, seq1[i]);
        checkOutput("s1.final_bin", int'(Bin_out), 0);
        checkOutput("s1.final_wrap", int'(Wrap), 1);
        checkOutput("s1.final_wc", int'(Wrap_count), 1);

        // Scenario 2: down-wrap from zero
        doReset("s2rst");
        applyStimulus("s2", 1'b0, 1'b1, 3'b000);
        applyStimulus("s2", 1'b0, 1'b1, 3'b100);
        checkOutput("s2.bin", int'(Bin_out), 7);
        checkOutput("s2.dir", int'(Dir), 0);
        checkOutput("s2.wc", int'(Wrap_count), 255);

        // Scenario 3: repeated sample gives Hold
        doReset("s3rst");
        applyStimulus("s3", 1'b0, 1'b1, 3'b011);
        applyStimulus("s3", 1'b0, 1'b1, 3'b011);
        checkOutput("s3.hold", int'(Hold), 1);
        checkOutput("s3.bin", int'(Bin_out), 2);

        // Scenario 4: illegal jump, then recovery behaviour depends on the build
        doReset("s4rst");
        applyStimulus("s4", 1'b0, 1'b1, 3'b001);
        applyStimulus("s4", 1'b0, 1'b1, 3'b101);
        checkOutput("s4.serr", int'(Step_err), 1);
        checkOutput("s4.bin", int'(Bin_out), 6);
        checkOutput("s4.locked", int'(Locked), 0);
        applyStimulus("s4", 1'b0, 1'b1, 3'b111);
`ifdef GRAY_DEC_STICKY_ERR_EN
        checkOutput("s4.sticky_ov", int'(Out_valid), 0);
        checkOutput("s4.sticky_err", int'(Err_flag), 1);
        checkOutput("s4.sticky_bin", int'(Bin_out), 6);
`else
        checkOutput("s4.resync_bin", int'(Bin_out), 5);
        checkOutput("s4.resync_locked", int'(Locked), 1);
        checkOutput("s4.resync_err", int'(Err_flag), 0);
`endif

        // Scenario 5: mid-stream Reset with a valid sample present
        doReset("s5rst");
        applyStimulus("s5", 1'b0, 1'b1, 3'b000);
        applyStimulus("s5", 1'b0, 1'b1, 3'b100);
        applyStimulus("s5r", 1'b1, 1'b1, 3'b011);
        checkOutput("s5.wc_cleared", int'(Wrap_count), 0);
        applyStimulus("s5", 1'b0, 1'b1, 3'b011);
        checkOutput("s5.resync_serr", int'(Step_err), 0);
        checkOutput("s5.resync_bin", int'(Bin_out), 2);

        // Scenario 6: idle cycles hold levels and drop pulses
        doReset("s6rst");
        applyStimulus("s6", 1'b0, 1'b1, 3'b001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("s6idle", 1'b0, 1'b0, int'($urandom_range(0, 7)));
            checkOutput("s6.idle_ov", int'(Out_valid), 0);
            checkOutput("s6.idle_bin", int'(Bin_out), 1);
        end
        applyStimulus("s6", 1'b0, 1'b1, 3'b011);
        checkOutput("s6.bin", int'(Bin_out), 2);
        checkOutput("s6.dir", int'(Dir), 1);

        // Randomized stimulus: mostly legal steps, some jumps, idles and resets
        doReset("rndrst");
        for (int i = 0; i < 400; i++) begin
            int r;
            int step;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                applyStimulus("rnd", 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            end else if (r < 20) begin
                applyStimulus("rnd", 1'b0, 1'b0, int'($urandom_range(0, 7)));
            end else if (r < 80) begin
                step = int'($urandom_range(0, 2)) - 1;
                applyStimulus("rnd", 1'b0, 1'b1, gray_of[(m_bin + step + N) % N]);
            end else begin
                applyStimulus("rnd", 1'b0, 1'b1, int'($urandom_range(0, 7)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
